// File: rtl/redirect_ctrl_pkg.sv
// redirect_ctrl shared types: source encodings, flush masks, FSM states.
// Source codes are ordered so that a larger value means an older stage.
package redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_ID   = 2'b01,
    SRC_EX   = 2'b10,
    SRC_TRAP = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PEND  = 2'b01,
    S_ISSUE = 2'b10
  } state_e;

  localparam int SHADOW_CYC_DEF = 2;

  localparam logic [2:0] FLUSH_ID   = 3'b001;
  localparam logic [2:0] FLUSH_EX   = 3'b011;
  localparam logic [2:0] FLUSH_TRAP = 3'b111;

  function automatic logic [2:0] flush_of(
    input src_e s
  );
    logic [2:0] m;
    m = 3'b000;
    case (s)
      SRC_ID:   m = FLUSH_ID;
      SRC_EX:   m = FLUSH_EX;
      SRC_TRAP: m = FLUSH_TRAP;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// Redirect request / issue bundle between the pipeline
// redirect sources, the stall unit and the PC register.
interface redirect_ctrl_if #(
  parameter int PC_W = 64
);
  logic            trap_redir_valid;
  logic [PC_W-1:0] trap_redir_pc;
  logic            ex_redir_valid;
  logic [PC_W-1:0] ex_redir_pc;
  logic            id_redir_valid;
  logic [PC_W-1:0] id_redir_pc;
  logic [4:0]      stall_ctrl;

  logic            redir_valid_o;
  logic [PC_W-1:0] redir_pc_o;
  logic [1:0]      redir_src_o;
  logic [2:0]      flush_o;
  logic            pend_o;

  modport master (
    output trap_redir_valid, trap_redir_pc,
    output ex_redir_valid, ex_redir_pc,
    output id_redir_valid, id_redir_pc,
    output stall_ctrl,
    input  redir_valid_o, redir_pc_o,
    input  redir_src_o, flush_o, pend_o
  );

  modport slave (
    input  trap_redir_valid, trap_redir_pc,
    input  ex_redir_valid, ex_redir_pc,
    input  id_redir_valid, id_redir_pc,
    input  stall_ctrl,
    output redir_valid_o, redir_pc_o,
    output redir_src_o, flush_o, pend_o
  );
endinterface

// File: rtl/redirect_ctrl_prio_sel.sv
// Eligibility filter and trap > EX > ID select, merged
// against a held entry (newer wins on equal or higher priority).
module redir_prio_sel
  import redirect_ctrl_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic            trap_v_i,
  input  logic [PC_W-1:0] trap_pc_i,
  input  logic            ex_v_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            id_v_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic            sh_zero_i,
  input  logic            st_v_i,
  input  src_e            st_src_i,
  input  logic [PC_W-1:0] st_pc_i,
  output logic            sel_v_o,
  output src_e            sel_src_o,
  output logic [PC_W-1:0] sel_pc_o
);

  logic            ex_ok;
  logic            id_ok;
  logic            trap_w;
  logic            ex_w;
  logic            id_w;
  logic            win_v;
  src_e            win_src;
  logic [PC_W-1:0] win_pc;

  assign ex_ok  = ex_v_i & sh_zero_i;
  assign id_ok  = id_v_i & sh_zero_i;
  assign trap_w = trap_v_i;
  assign ex_w   = ex_ok & ~trap_v_i;
  assign id_w   = id_ok & ~trap_v_i & ~ex_ok;

  always_comb begin
    win_v   = 1'b0;
    win_src = SRC_NONE;
    win_pc  = '0;
    unique case (1'b1)
      trap_w: begin
        win_v   = 1'b1;
        win_src = SRC_TRAP;
        win_pc  = trap_pc_i;
      end
      ex_w: begin
        win_v   = 1'b1;
        win_src = SRC_EX;
        win_pc  = ex_pc_i;
      end
      id_w: begin
        win_v   = 1'b1;
        win_src = SRC_ID;
        win_pc  = id_pc_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_v_o   = st_v_i;
    sel_src_o = st_src_i;
    sel_pc_o  = st_pc_i;
    if (win_v && (!st_v_i || (win_src >= st_src_i))) begin
      sel_v_o   = 1'b1;
      sel_src_o = win_src;
      sel_pc_o  = win_pc;
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect controller: arbitrates, holds across
// stalls, issues one registered pulse, then shadows ID/EX.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int PC_W       = 64,
  parameter int SHADOW_CYC = SHADOW_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  redirect_ctrl_if.slave   bus
);

  state_e          state_q, state_d;
  logic            st_v_q, st_v_d;
  src_e            st_src_q, st_src_d;
  logic [PC_W-1:0] st_pc_q, st_pc_d;
  logic [2:0]      sh_q, sh_d;
  logic            vld_q, vld_d;
  src_e            src_q, src_d;
  logic [2:0]      fl_q, fl_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic            free;
  logic            sel_v;
  src_e            sel_src;
  logic [PC_W-1:0] sel_pc;
  logic            issue;
  logic            unused_stall;

  assign free = (bus.stall_ctrl[1:0] == 2'b00);
  assign unused_stall = ^bus.stall_ctrl[4:2];

  redir_prio_sel #(
    .PC_W (PC_W)
  ) u_sel (
    .trap_v_i  (bus.trap_redir_valid),
    .trap_pc_i (bus.trap_redir_pc),
    .ex_v_i    (bus.ex_redir_valid),
    .ex_pc_i   (bus.ex_redir_pc),
    .id_v_i    (bus.id_redir_valid),
    .id_pc_i   (bus.id_redir_pc),
    .sh_zero_i (sh_q == 3'd0),
    .st_v_i    (st_v_q),
    .st_src_i  (st_src_q),
    .st_pc_i   (st_pc_q),
    .sel_v_o   (sel_v),
    .sel_src_o (sel_src),
    .sel_pc_o  (sel_pc)
  );

  always_comb begin
    state_d  = S_IDLE;
    st_v_d   = 1'b0;
    st_src_d = SRC_NONE;
    st_pc_d  = '0;
    issue    = 1'b0;
    unique case (state_q)
      S_IDLE, S_ISSUE, S_PEND: begin
        if (sel_v && free) begin
          state_d = S_ISSUE;
          issue   = 1'b1;
        end else if (sel_v) begin
          state_d  = S_PEND;
          st_v_d   = 1'b1;
          st_src_d = sel_src;
          st_pc_d  = sel_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Older-stage issues open a window that blocks wrong-path ID/EX.
  always_comb begin
    sh_d = sh_q;
    if (issue && (sel_src == SRC_EX || sel_src == SRC_TRAP)) begin
      sh_d = 3'(SHADOW_CYC);
    end else if (free && sh_q != 3'd0) begin
      sh_d = sh_q - 3'd1;
    end
  end

  always_comb begin
    vld_d = issue;
    src_d = issue ? sel_src : SRC_NONE;
    fl_d  = issue ? flush_of(sel_src) : 3'b000;
    pc_d  = issue ? sel_pc : pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      st_v_q   <= 1'b0;
      st_src_q <= SRC_NONE;
      st_pc_q  <= '0;
      sh_q     <= 3'd0;
      vld_q    <= 1'b0;
      src_q    <= SRC_NONE;
      fl_q     <= 3'b000;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      st_v_q   <= st_v_d;
      st_src_q <= st_src_d;
      st_pc_q  <= st_pc_d;
      sh_q     <= sh_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
      fl_q     <= fl_d;
      pc_q     <= pc_d;
    end
  end

  assign bus.redir_valid_o = vld_q;
  assign bus.redir_pc_o    = pc_q;
  assign bus.redir_src_o   = src_q;
  assign bus.flush_o       = fl_q;
  assign bus.pend_o        = (state_q == S_PEND);

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end redirect controller that sits between the ID/EX/trap redirect sources and the PC register. It arbitrates simultaneous redirect requests by pipeline age (trap > EX > ID) and holds a pending redirect while the front end is stalled. It issues exactly one registered redirect pulse with matching stage-flush masks, then shadows wrong-path ID/EX requests for a programmable number of unstalled cycles.

## Interface
Parameters:
- PC_W, 64, redirect address width
- SHADOW_CYC, 2, unstalled cycles after an EX/trap issue during which ID/EX requests are dropped (1..7)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- trap_redir_valid  in  1  trap/CSR redirect request (mtvec/mepc)
- trap_redir_pc  in  PC_W  trap target
- ex_redir_valid  in  1  EX branch-mispredict redirect request
- ex_redir_pc  in  PC_W  EX target
- id_redir_valid  in  1  ID jump redirect request
- id_redir_pc  in  PC_W  ID target
- stall_ctrl  in  5  pipeline stall vector; bits [1:0] = PC/IF stall, 1 = stop
- redir_valid_o  out  1  one-cycle redirect pulse to PC register
- redir_pc_o  out  PC_W  redirect target, valid with redir_valid_o
- redir_src_o  out  2  00 none, 01 ID, 10 EX, 11 trap
- flush_o  out  3  [0] IF, [1] ID, [2] EX flush, pulse with redir_valid_o
- pend_o  out  1  redirect held, waiting for stall release

## Operation
- Front end free when stall_ctrl[1:0] == 2'b00; bits [4:2] ignored.
- Accept filter per cycle: trap always eligible; EX and ID eligible only when shadow counter == 0.
- Priority among eligible requests: trap > EX > ID; one winner per cycle.
- FSM states IDLE, PEND, ISSUE:
  - IDLE/ISSUE: winner and free -> ISSUE (load winner into output regs); winner and stalled -> PEND (store winner); no winner -> IDLE.
  - PEND: new winner of priority >= stored replaces stored; lower priority dropped; when free -> ISSUE with stored (or replacing) entry; stalled -> stay PEND.
- ISSUE: redir_valid_o = 1, redir_pc_o/redir_src_o from issued entry, flush_o per source: ID 3'b001, EX 3'b011, trap 3'b111.
- Shadow counter loads SHADOW_CYC on the edge entering ISSUE for EX/trap sources (not ID); decrements on every free cycle while nonzero; holds while stalled.
- pend_o = (state == PEND).
- Outside ISSUE: redir_valid_o = 0, flush_o = 0, redir_src_o = 00, redir_pc_o holds last issued value.

## Timing
- Reset (rst low, async): state IDLE, shadow 0, stored entry cleared; redir_valid_o 0, redir_pc_o 0, redir_src_o 00, flush_o 000, pend_o 0. Reset mid-PEND drops the held redirect.
- Latency: request in cycle N with front end free -> pulse in N+1.
- Stalled request: pulse in the cycle after the first free cycle.
- Back-to-back: a request in an ISSUE cycle may produce ISSUE again next cycle (e.g., trap right after an EX issue).
- Request held high across stall: re-sampled each cycle (same priority overwrites, same value); no duplicate pulse after issue beyond shadow rules. ID/EX sources must drop valid once redir_valid_o is seen.
- Shadow example, SHADOW_CYC=2, all free: EX issue pulse at N+1 (counter 2), N+2 counter 1, ID/EX accepted again from N+3.

## Structure
- Shared package: source encodings (SRC_NONE/ID/EX/TRAP), flush masks per source, FSM state enum, default SHADOW_CYC.
- Sub-module redir_prio_sel: combinational eligibility filter plus trap>EX>ID priority select, outputs winner valid/src/pc; instantiated for the incoming-vs-stored comparison.

## Test plan
- Simultaneous trap 0x8000_0100, EX 0x8000_0200, ID 0x8000_0300, front end free -> next cycle one pulse, pc 0x8000_0100, src 11, flush 111.
- EX 0x8000_0040 with stall_ctrl=5'b00011 for 3 cycles -> pend_o 1 for 3 cycles, pulse with 0x8000_0040, flush 011 the cycle after release.
- During PEND holding ID 0x100, EX 0x200 arrives -> replaced; pulse pc 0x200 src 10; separate test with ID arriving over stored EX -> stays EX.
- EX issue, then ID request on each of next 3 cycles (SHADOW_CYC=2) -> ID dropped in pulse cycle and next cycle, accepted on third, second pulse src 01 flush 001.
- Trap arriving in EX-shadow cycle -> accepted, pulse next cycle src 11, counter reloaded.
- Assert rst low mid-PEND asynchronously -> all outputs 0 immediately; after release, no pulse without new request.
